chime_sequencer: RTL

//  Hourly chime stage downstream of the clock core: consumes hour/minute/second, and on each new
//  hh:00:00 drives the speaker with N beeps (N = hour mod 12, 0 -> 12) of a fixed-frequency square wave.

---
 rtl/chime_pkg.sv | 38 +++
 rtl/tone_gen.sv | 43 ++++
 rtl/chime_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/chime_pkg.sv
// Shared state encoding, timing helpers and the hour-to-beep-count mapping for chime_sequencer.
package chime_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned DEF_CLK_HZ  = 100_000_000;
    localparam int unsigned DEF_TONE_HZ = 1000;
    localparam int unsigned DEF_ON_MS   = 200;
    localparam int unsigned DEF_OFF_MS  = 300;

    function automatic int unsigned ms_div_of(input int unsigned clk_hz);
        return (clk_hz < 1000) ? 1 : clk_hz / 1000;
    endfunction

    function automatic int unsigned half_of(input int unsigned clk_hz, input int unsigned tone_hz);
        int unsigned h;
        h = clk_hz / (2 * tone_hz);
        return (h == 0) ? 1 : h;
    endfunction

    localparam int unsigned MS_DIV    = ms_div_of(DEF_CLK_HZ);
    localparam int unsigned ON_TICKS  = DEF_ON_MS * MS_DIV;
    localparam int unsigned OFF_TICKS = DEF_OFF_MS * MS_DIV;
    localparam int unsigned HALF      = half_of(DEF_CLK_HZ, DEF_TONE_HZ);

    // Twelve-hour dial: midnight and noon ring twelve times.
    function automatic logic [3:0] beeps_for_hour(input logic [5:0] hour);
        logic [5:0] h12;
        h12 = (hour >= 6'd12) ? hour - 6'd12 : hour;
        return (h12 == 6'd0) ? 4'd12 : 4'(h12);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Reloadable square-wave divider: held low while restart is high, then starts high
// and toggles every half_period cycles.
module tone_gen
    import chime_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [CNT_W-1:0] half_period,
    output logic             square
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (restart) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (cnt_q == '0) begin
            // A zero count marks a phase boundary, so the first running cycle flips low->high.
            cnt_d = half_period - CNT_W'(1);
            sq_d  = ~sq_q;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign square = sq_q;

endmodule

// File: rtl/chime_sequencer.sv
// Hourly chime: on each new hh:00:00, plays (hour mod 12, 0 -> 12) beeps on speak.
// Define CHIME_ALARM_EN to add the alarm_hour/alarm_min/alarm_set alarm sequence.
module chime_sequencer
    import chime_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned TONE_HZ     = DEF_TONE_HZ,
    parameter int unsigned BEEP_ON_MS  = DEF_ON_MS,
    parameter int unsigned BEEP_OFF_MS = DEF_OFF_MS,
    parameter int unsigned ALARM_BEEPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
`ifdef CHIME_ALARM_EN
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_set,
`endif
    output logic       speak,
    output logic       busy,
    output logic [3:0] beeps_left
);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(ms_div_of(CLK_HZ) - 1);
    localparam logic [15:0]      ON_LAST    = 16'(BEEP_ON_MS - 1);
    localparam logic [15:0]      OFF_LAST   = 16'(BEEP_OFF_MS - 1);
    localparam logic [CNT_W-1:0] HALF_CHIME = CNT_W'(half_of(CLK_HZ, TONE_HZ));
    localparam logic [CNT_W-1:0] HALF_ALARM = CNT_W'(half_of(CLK_HZ, 2 * TONE_HZ));
    localparam logic [3:0]       ALARM_N    = 4'(ALARM_BEEPS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [15:0]      ms_q, ms_d;
    logic [3:0]       beeps_q, beeps_d;
    logic             alarm_q, alarm_d;
    logic             busy_q, busy_d;
    logic [17:0]      time_q, time_d;
    logic             hist_q, hist_d;

    logic             new_time, chime_trig, alarm_trig, abort;
    logic             pre_wrap, phase_done, tone_hold;
    logic [CNT_W-1:0] half_sel;

    always_comb begin
        time_d     = {hour, minute, second};
        hist_d     = 1'b1;
        new_time   = !hist_q || (time_q != time_d);
        chime_trig = en && new_time && (hour <= 6'd23) && (minute == 6'd0) && (second == 6'd0);
`ifdef CHIME_ALARM_EN
        alarm_trig = en && alarm_set && new_time && (hour <= 6'd23) && (minute <= 6'd59)
                     && (second == 6'd0) && (hour == alarm_hour) && (minute == alarm_min);
        abort      = !en || (alarm_q && !alarm_set);
`else
        alarm_trig = 1'b0;
        abort      = !en;
`endif
    end

    always_comb begin
        state_d    = state_q;
        beeps_d    = beeps_q;
        alarm_d    = alarm_q;
        pre_wrap   = (pre_q == PRE_LAST);
        pre_d      = pre_wrap ? '0 : pre_q + CNT_W'(1);
        ms_d       = pre_wrap ? ms_q + 16'd1 : ms_q;
        phase_done = pre_wrap && (ms_q == ((state_q == ST_TONE) ? ON_LAST : OFF_LAST));

        if ((state_q != ST_IDLE) && abort) begin
            state_d = ST_IDLE;
            beeps_d = 4'd0;
            alarm_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (chime_trig || alarm_trig) begin
                        state_d = ST_TONE;
                        beeps_d = alarm_trig ? ALARM_N : beeps_for_hour(hour);
                        alarm_d = alarm_trig;
                    end
                end
                ST_TONE: begin
                    if (phase_done) begin
                        beeps_d = beeps_q - 4'd1;
                        state_d = (beeps_q == 4'd1) ? ST_IDLE : ST_GAP;
                        if (beeps_q == 4'd1) alarm_d = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (phase_done) state_d = ST_TONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Each phase is timed from its own entry, so the prescaler restarts on any state change.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            pre_d = '0;
            ms_d  = '0;
        end

        busy_d    = (state_d != ST_IDLE);
        tone_hold = (state_d != ST_TONE);
        half_sel  = alarm_d ? HALF_ALARM : HALF_CHIME;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            beeps_q <= 4'd0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
            time_q  <= '0;
            hist_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            beeps_q <= beeps_d;
            alarm_q <= alarm_d;
            busy_q  <= busy_d;
            time_q  <= time_d;
            hist_q  <= hist_d;
        end
    end

    tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .restart     (tone_hold),
        .half_period (half_sel),
        .square      (speak)
    );

    assign busy       = busy_q;
    assign beeps_left = beeps_q;

endmodule
